// File: rtl/riscv_ctrl_pkg.sv
// Shared constants and types for the multi-cycle execute controller.
// Opcodes, ALU operation codes and the controller state encoding.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      IDLE,
      DECODE,
      EXEC,
      WB
   } state_t;

   // funct3 -> ALU code shared by R-type and I-type arithmetic
   function automatic logic [3:0] f3_alu(input logic [2:0] f3);
      logic [3:0] r;
      r = {1'b0, ALU_ADD};
      case (f3)
         3'b000: r = {1'b1, ALU_ADD};
         3'b100: r = {1'b1, ALU_XOR};
         3'b110: r = {1'b1, ALU_OR};
         3'b111: r = {1'b1, ALU_AND};
         3'b010: r = {1'b1, ALU_SLT};
         default: r = {1'b0, ALU_ADD};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/riscv_exec_ctrl_decode.sv
// Combinational instruction decoder for the execute controller.
// Maps the latched instruction to ALU control, immediate and legality.
module riscv_decode
   import riscv_ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic [31:0]       ir,
   output logic [REG_AW-1:0] rs1,
   output logic [REG_AW-1:0] rs2,
   output logic [REG_AW-1:0] rd,
   output logic [2:0]        alu_ctrl,
   output logic              alu_src_imm,
   output logic [XLEN-1:0]   imm,
   output logic              legal
);

   logic [6:0] opc;
   logic [6:0] f7;
   logic [2:0] f3;
   logic [3:0] f3d;
   logic       is_r;
   logic       is_i;

   assign opc  = ir[6:0];
   assign f3   = ir[14:12];
   assign f7   = ir[31:25];
   assign f3d  = f3_alu(f3);
   assign is_r = (opc == OP_RTYPE);
   assign is_i = (opc == OP_ITYPE);

   assign rs1 = REG_AW'(ir[19:15]);
   assign rd  = REG_AW'(ir[11:7]);

   always_comb begin
      alu_ctrl    = ALU_ADD;
      alu_src_imm = 1'b0;
      imm         = '0;
      legal       = 1'b0;
      rs2         = REG_AW'(ir[24:20]);
      unique case (1'b1)
         is_r && f7 == F7_BASE && f3d[3]: begin
            legal    = 1'b1;
            alu_ctrl = f3d[2:0];
         end
         is_r && f7 == F7_ALT && f3 == 3'b000: begin
            legal    = 1'b1;
            alu_ctrl = ALU_SUB;
         end
         is_i && f3d[3]: begin
            legal       = 1'b1;
            alu_ctrl    = f3d[2:0];
            alu_src_imm = 1'b1;
            imm         = {{(XLEN-12){ir[31]}}, ir[31:20]};
            rs2         = '0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/riscv_exec_ctrl.sv
// Multi-cycle IDLE/DECODE/EXEC/WB controller for regfile and ALU.
// Optional RETIRE_CNT_EN adds a legal-retire counter output.
module riscv_exec_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic              stall,
   output logic [REG_AW-1:0] rs1_addr,
   output logic [REG_AW-1:0] rs2_addr,
   output logic [REG_AW-1:0] rd_addr,
   output logic [2:0]        alu_ctrl,
   output logic              alu_src_imm,
   output logic [XLEN-1:0]   imm,
   output logic              reg_write,
   output logic              retire,
   output logic              illegal,
   output logic              busy
`ifdef RETIRE_CNT_EN
   ,
   output logic [31:0]       retire_count
`endif
);

   state_t state;
   state_t state_n;

   logic [31:0]       ir;
   logic              legal_q;
   logic [REG_AW-1:0] d_rs1;
   logic [REG_AW-1:0] d_rs2;
   logic [REG_AW-1:0] d_rd;
   logic [2:0]        d_alu;
   logic              d_src;
   logic [XLEN-1:0]   d_imm;
   logic              d_legal;

   riscv_decode #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
   ) u_dec (
      .ir          (ir),
      .rs1         (d_rs1),
      .rs2         (d_rs2),
      .rd          (d_rd),
      .alu_ctrl    (d_alu),
      .alu_src_imm (d_src),
      .imm         (d_imm),
      .legal       (d_legal)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (instr_valid) state_n = DECODE;
         DECODE:  state_n = EXEC;
         EXEC:    if (!stall) state_n = WB;
         WB:      state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ir          <= '0;
         legal_q     <= 1'b0;
         rs1_addr    <= '0;
         rs2_addr    <= '0;
         rd_addr     <= '0;
         alu_ctrl    <= ALU_ADD;
         alu_src_imm <= 1'b0;
         imm         <= '0;
      end else begin
         if (state == IDLE && instr_valid) ir <= instr;
         if (state == DECODE) begin
            legal_q     <= d_legal;
            rs1_addr    <= d_rs1;
            rs2_addr    <= d_rs2;
            rd_addr     <= d_rd;
            alu_ctrl    <= d_alu;
            alu_src_imm <= d_src;
            imm         <= d_imm;
         end
      end
   end

   // Strobes come straight from WB so a reset drops any pending write
   assign instr_ready = (state == IDLE);
   assign busy        = (state != IDLE);
   assign retire      = (state == WB);
   assign illegal     = retire && !legal_q;
   assign reg_write   = retire && legal_q && (rd_addr != '0);

`ifdef RETIRE_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n)                retire_count <= '0;
      else if (retire && legal_q) retire_count <= retire_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_riscv_exec_ctrl.sv
// Directed self-checking bench for riscv_exec_ctrl.
// Counter checks are compiled in only with RETIRE_CNT_EN.
module tb_riscv_exec_ctrl;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        stall;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [4:0]  rd_addr;
   logic [2:0]  alu_ctrl;
   logic        alu_src_imm;
   logic [31:0] imm;
   logic        reg_write;
   logic        retire;
   logic        illegal;
   logic        busy;
`ifdef RETIRE_CNT_EN
   logic [31:0] retire_count;
`endif

   int checks = 0;
   int errors = 0;

   riscv_exec_ctrl #(
      .XLEN   (32),
      .REG_AW (5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .stall       (stall),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rd_addr     (rd_addr),
      .alu_ctrl    (alu_ctrl),
      .alu_src_imm (alu_src_imm),
      .imm         (imm),
      .reg_write   (reg_write),
      .retire      (retire),
      .illegal     (illegal),
      .busy        (busy)
`ifdef RETIRE_CNT_EN
      ,
      .retire_count (retire_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one-cycle valid pulse; returns in DECODE
   task automatic issue(input logic [31:0] w);
      instr       = w;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      instr       = '0;
      instr_valid = 1'b0;
      stall       = 1'b0;
      tick();
      tick();
      chk("rst_ready", instr_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_retire", retire, 0);
      chk("rst_regwr", reg_write, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_rd", rd_addr, 0);
      chk("rst_imm", imm, 0);
      chk("rst_alu", alu_ctrl, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_ready", instr_ready, 1);

      // add x3,x1,x2
      issue(32'h002081B3);
      chk("add_dec_busy", busy, 1);
      chk("add_dec_ready", instr_ready, 0);
      chk("add_dec_retire", retire, 0);
      tick();
      chk("add_rs1", rs1_addr, 1);
      chk("add_rs2", rs2_addr, 2);
      chk("add_rd", rd_addr, 3);
      chk("add_alu", alu_ctrl, 3'b000);
      chk("add_src", alu_src_imm, 0);
      chk("add_ex_regwr", reg_write, 0);
      tick();
      chk("add_wb_regwr", reg_write, 1);
      chk("add_wb_retire", retire, 1);
      chk("add_wb_illegal", illegal, 0);
      tick();
      chk("add_post_retire", retire, 0);
      chk("add_post_ready", instr_ready, 1);

      // sub x3,x1,x2
      issue(32'h402081B3);
      tick();
      chk("sub_alu", alu_ctrl, 3'b001);
      chk("sub_src", alu_src_imm, 0);
      tick();
      chk("sub_regwr", reg_write, 1);
      tick();

      // addi x5,x0,-1
      issue(32'hFFF00293);
      tick();
      chk("addi_src", alu_src_imm, 1);
      chk("addi_imm", imm, 32'hFFFFFFFF);
      chk("addi_rd", rd_addr, 5);
      chk("addi_rs2", rs2_addr, 0);
      chk("addi_alu", alu_ctrl, 3'b000);
      tick();
      chk("addi_regwr", reg_write, 1);
      tick();

      // add x0,x1,x2: retires without a write
      issue(32'h00208033);
      tick();
      tick();
      chk("x0_retire", retire, 1);
      chk("x0_regwr", reg_write, 0);
      chk("x0_illegal", illegal, 0);
      tick();

      // all-zero word is illegal
      issue(32'h00000000);
      tick();
      chk("ill_alu", alu_ctrl, 0);
      chk("ill_src", alu_src_imm, 0);
      chk("ill_imm", imm, 0);
      tick();
      chk("ill_retire", retire, 1);
      chk("ill_illegal", illegal, 1);
      chk("ill_regwr", reg_write, 0);
      tick();
`ifdef RETIRE_CNT_EN
      chk("cnt_after_ill", retire_count, 4);
`endif

      // xori x6,x1,5 with 4 stall cycles and a competing valid
      issue(32'h0050C313);
      stall = 1'b1;
      tick();
      instr       = 32'h002081B3;
      instr_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("stl_ready", instr_ready, 0);
         chk("stl_retire", retire, 0);
         chk("stl_imm", imm, 5);
         chk("stl_alu", alu_ctrl, 3'b100);
         chk("stl_rd", rd_addr, 6);
         tick();
      end
      stall       = 1'b0;
      instr_valid = 1'b0;
      chk("stl_still_ex", retire, 0);
      tick();
      chk("stl_wb_regwr", reg_write, 1);
      chk("stl_wb_rd", rd_addr, 6);
      chk("stl_wb_src", alu_src_imm, 1);
      tick();
      chk("stl_idle_ready", instr_ready, 1);
      chk("stl_hold_rs1", rs1_addr, 1);
      chk("stl_hold_imm", imm, 5);
      tick();
      chk("stl_not_taken", busy, 0);

      // reset during EXEC
      issue(32'h002081B3);
      tick();
      chk("rmo_in_ex", busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rmo_busy", busy, 0);
      chk("rmo_ready", instr_ready, 1);
      chk("rmo_regwr", reg_write, 0);
      chk("rmo_retire", retire, 0);
      chk("rmo_rd", rd_addr, 0);
      tick();
      chk("rmo_idle_regwr", reg_write, 0);
      issue(32'h002081B3);
      tick();
      tick();
      chk("rmo_add_regwr", reg_write, 1);
      chk("rmo_add_retire", retire, 1);
      tick();

      // back-to-back with valid held high, after a fresh reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      instr       = 32'h002081B3;
      instr_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (i == 11) instr_valid = 1'b0;
         chk("b2b_retire", retire, (i % 4 == 2) ? 1 : 0);
         chk("b2b_ready", instr_ready, (i % 4 == 3) ? 1 : 0);
      end
      tick();
      chk("b2b_end_idle", busy, 0);
`ifdef RETIRE_CNT_EN
      chk("b2b_count", retire_count, 3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
